// File: rtl/background_pkg.sv
// Shared types and defaults for the background engine.
package background_pkg;
    typedef enum logic [1:0] {BG_SOLID, BG_XOR, BG_DIAG, BG_BANDS} bg_mode_e;
    localparam int BG_COLOR_W = 6;
endpackage

// File: rtl/bg_time_gen.sv
// Animation time base: shadow speed/direction, frame divider and up/down time counter.
module bg_time_gen #(
    parameter int TIME_W = 8
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_frame_start,
    input  logic [2:0]        i_cfg_speed,
    input  logic              i_cfg_dir,
    output logic [TIME_W-1:0] o_cur_time
);
    logic [2:0]        r_speed;
    logic              r_dir;
    logic [2:0]        r_div;
    logic [TIME_W-1:0] r_time;
    logic [2:0]        w_speed;
    logic              w_dir;

    // The divider compares against the speed captured on this very pulse.
    assign w_speed = i_frame_start ? i_cfg_speed : r_speed;
    assign w_dir   = i_frame_start ? i_cfg_dir   : r_dir;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_speed <= '0;
            r_dir   <= 1'b0;
            r_div   <= '0;
            r_time  <= '0;
        end else if (i_frame_start) begin
            r_speed <= w_speed;
            r_dir   <= w_dir;
            if (w_speed == 3'd0) begin
                r_div <= '0;
            end else if (r_div >= w_speed - 3'd1) begin
                // >= keeps a lowered speed from stalling the divider for a full wrap
                r_div  <= '0;
                r_time <= w_dir ? r_time - TIME_W'(1) : r_time + TIME_W'(1);
            end else begin
                r_div <= r_div + 3'd1;
            end
        end
    end

    assign o_cur_time = r_time;
endmodule

// File: rtl/background_engine.sv
// Registered background pattern generator with internal palette and frame-synchronous config.
module background_engine
    import background_pkg::*;
#(
    parameter int HTOTAL       = 800,
    parameter int VTOTAL       = 525,
    parameter int COLOR_W      = BG_COLOR_W,
    parameter int NUM_COLORS   = 4,
    parameter int TIME_W       = 8,
    parameter int STRIPE_SHIFT = 5,
    localparam int HW          = $clog2(HTOTAL) + 1,
    localparam int VW          = $clog2(VTOTAL) + 1,
    localparam int PAL_AW      = $clog2(NUM_COLORS)
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic               i_frame_start,
    input  logic [HW-1:0]      i_counter_h,
    input  logic [VW-1:0]      i_counter_v,
    input  logic [1:0]         i_cfg_mode,
    input  logic [2:0]         i_cfg_speed,
    input  logic               i_cfg_dir,
    input  logic               i_pal_we,
    input  logic [PAL_AW-1:0]  i_pal_addr,
    input  logic [COLOR_W-1:0] i_pal_wdata,
    output logic [COLOR_W-1:0] o_color_out,
    output logic [TIME_W-1:0]  o_cur_time
);
    localparam int W = ((HW > VW) ? HW : VW) + 2;

    logic [COLOR_W-1:0] r_pal [NUM_COLORS];
    bg_mode_e           r_mode;
    logic [COLOR_W-1:0] r_color;

    logic [W-1:0]       w_h, w_v, w_t;
    logic [W-1:0]       w_sum_d, w_sum_b;
    logic [PAL_AW-1:0]  w_idx_d, w_idx_b;
    logic [6:0]         w_xor;
    logic [COLOR_W-1:0] w_color;
    logic [TIME_W-1:0]  w_time;

    bg_time_gen #(.TIME_W(TIME_W)) u_time (
        .i_clk         (i_clk),
        .i_reset_n     (i_reset_n),
        .i_frame_start (i_frame_start),
        .i_cfg_speed   (i_cfg_speed),
        .i_cfg_dir     (i_cfg_dir),
        .o_cur_time    (w_time)
    );

    assign w_h = {{(W-HW){i_counter_h[HW-1]}}, i_counter_h};
    assign w_v = {{(W-VW){i_counter_v[VW-1]}}, i_counter_v};
    assign w_t = W'(w_time);

    assign w_sum_d = w_h + w_v + w_t;
    assign w_sum_b = w_v + w_t;
    assign w_idx_d = PAL_AW'(w_sum_d >> STRIPE_SHIFT);
    assign w_idx_b = PAL_AW'(w_sum_b >> STRIPE_SHIFT);
    assign w_xor   = {1'b0, w_h[7:2] ^ w_v[7:2]} + {1'b0, w_t[7:2]};

    always_comb begin
        w_color = '0;
        case (r_mode)
            BG_SOLID: w_color = r_pal[0];
            BG_XOR:   w_color = COLOR_W'(w_xor);
            BG_DIAG:  w_color = r_pal[w_idx_d];
            BG_BANDS: w_color = r_pal[w_idx_b];
            default:  w_color = '0;
        endcase
    end

    // Lookups read the palette before this edge's write lands, so a colliding pixel sees the old entry.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            for (int i = 0; i < NUM_COLORS; i++) r_pal[i] <= '0;
            r_mode  <= BG_SOLID;
            r_color <= '0;
        end else begin
            r_color <= w_color;
            if (i_pal_we) r_pal[i_pal_addr] <= i_pal_wdata;
            if (i_frame_start) r_mode <= bg_mode_e'(i_cfg_mode);
        end
    end

    assign o_color_out = r_color;
    assign o_cur_time  = w_time;
endmodule

// File: tb/tb_background_engine.sv
// Directed and randomized checks of background_engine against a frame-level behavioural model.
module tb_background_engine;
    logic              clk = 1'b0;
    logic              rst_n;
    logic              fs;
    logic signed [10:0] h, v;
    logic [1:0]        cfg_mode;
    logic [2:0]        cfg_speed;
    logic              cfg_dir;
    logic              pal_we;
    logic [1:0]        pal_addr;
    logic [5:0]        pal_wdata;
    logic [5:0]        color;
    logic [7:0]        cur_time;

    int checks = 0;
    int errors = 0;

    background_engine dut (
        .i_clk         (clk),
        .i_reset_n     (rst_n),
        .i_frame_start (fs),
        .i_counter_h   (h),
        .i_counter_v   (v),
        .i_cfg_mode    (cfg_mode),
        .i_cfg_speed   (cfg_speed),
        .i_cfg_dir     (cfg_dir),
        .i_pal_we      (pal_we),
        .i_pal_addr    (pal_addr),
        .i_pal_wdata   (pal_wdata),
        .o_color_out   (color),
        .o_cur_time    (cur_time)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: whole-frame bookkeeping in plain integers.
    int m_pal [4];
    int m_mode, m_div, m_time;
    int exp_color, exp_time;
    bit mvalid = 0;

    function automatic int model_color(int mode, int hi, int vi, int ti);
        int s;
        case (mode)
            0: return m_pal[0];
            1: return ((((hi & 255) >> 2) ^ ((vi & 255) >> 2)) + ((ti & 255) >> 2)) & 63;
            2: begin s = hi + vi + ti; return m_pal[((s & 8191) >> 5) & 3]; end
            default: begin s = vi + ti; return m_pal[((s & 8191) >> 5) & 3]; end
        endcase
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) m_pal[i] = 0;
            m_mode = 0; m_div = 0; m_time = 0; exp_color = 0;
            mvalid = 1;
        end else begin
            exp_color = model_color(m_mode, int'(h), int'(v), m_time);
            if (pal_we) m_pal[pal_addr] = int'(pal_wdata);
            if (fs) begin
                m_mode = int'(cfg_mode);
                if (cfg_speed == 0) m_div = 0;
                else if (m_div >= int'(cfg_speed) - 1) begin
                    m_div  = 0;
                    m_time = (m_time + (cfg_dir ? 255 : 1)) % 256;
                end else m_div++;
            end
        end
        exp_time = m_time;
    end

    always @(negedge clk) begin
        if (mvalid) begin
            chk("model_color", {26'd0, color}, exp_color);
            chk("model_time", {24'd0, cur_time}, exp_time);
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse();
        fs = 1'b1; step();
        fs = 1'b0; step();
    endtask

    task automatic rand_pixel();
        h = 11'($urandom_range(0, 2047));
        v = 11'($urandom_range(0, 2047));
    endtask

    initial begin
        rst_n = 1'b0; fs = 1'b0; h = '0; v = '0;
        cfg_mode = '0; cfg_speed = '0; cfg_dir = 1'b0;
        pal_we = 1'b0; pal_addr = '0; pal_wdata = '0;

        repeat (2) begin
            fs = 1'($urandom); pal_we = 1'($urandom); pal_addr = 2'($urandom);
            pal_wdata = 6'($urandom); cfg_mode = 2'($urandom);
            cfg_speed = 3'($urandom); cfg_dir = 1'($urandom); rand_pixel();
            step();
        end
        chk("reset_color", {26'd0, color}, 0);
        chk("reset_time", {24'd0, cur_time}, 0);

        rst_n = 1'b1; fs = 1'b0; pal_we = 1'b0;
        cfg_mode = 2'd0; cfg_speed = 3'd0; cfg_dir = 1'b0;
        step();
        chk("solid_after_reset", {26'd0, color}, 0);

        pal_we = 1'b1; pal_addr = 2'd0; pal_wdata = 6'h2A; step();
        pal_we = 1'b0;
        pulse();
        for (int i = 0; i < 3; i++) begin
            rand_pixel(); step();
            chk("shadow_solid", {26'd0, color}, 'h2A);
        end
        cfg_mode = 2'd3;
        for (int i = 0; i < 3; i++) begin
            rand_pixel(); step();
            chk("no_pulse_hold", {26'd0, color}, 'h2A);
        end

        cfg_mode = 2'd0; cfg_speed = 3'd3; cfg_dir = 1'b0;
        repeat (9) pulse();
        chk("speed3_nine", {24'd0, cur_time}, 3);
        cfg_speed = 3'd0;
        repeat (5) pulse();
        chk("speed0_hold", {24'd0, cur_time}, 3);

        rst_n = 1'b0; step();
        chk("midreset_color", {26'd0, color}, 0);
        chk("midreset_time", {24'd0, cur_time}, 0);
        rst_n = 1'b1;

        cfg_speed = 3'd1; cfg_dir = 1'b1; pulse();
        chk("wrap_down", {24'd0, cur_time}, 255);
        cfg_dir = 1'b0; pulse();
        chk("wrap_up", {24'd0, cur_time}, 0);

        cfg_speed = 3'd0;
        for (int i = 0; i < 4; i++) begin
            pal_we = 1'b1; pal_addr = 2'(i); pal_wdata = 6'(i + 1); step();
        end
        pal_we = 1'b0;
        cfg_mode = 2'd2; pulse();
        h = 11'sd0;  v = 11'sd0;  step(); chk("diag_0_0", {26'd0, color}, 'h01);
        h = 11'sd32; v = 11'sd0;  step(); chk("diag_32_0", {26'd0, color}, 'h02);
        h = -11'sd1; v = 11'sd0;  step(); chk("diag_m1_0", {26'd0, color}, 'h04);
        h = 11'sd0;  v = 11'sd64; step(); chk("diag_0_64", {26'd0, color}, 'h03);

        cfg_mode = 2'd1; pulse();
        h = 11'sd12; v = 11'sd4; step(); chk("xor_12_4", {26'd0, color}, 'h02);

        cfg_mode = 2'd0; pulse();
        h = 11'sd5; pal_we = 1'b1; pal_addr = 2'd0; pal_wdata = 6'h11; step();
        chk("collide_old", {26'd0, color}, 'h01);
        pal_we = 1'b0; h = 11'sd6; step();
        chk("collide_new", {26'd0, color}, 'h11);

        for (int n = 0; n < 3000; n++) begin
            rst_n     = ($urandom_range(0, 99) != 0);
            fs        = ($urandom_range(0, 7) == 0);
            cfg_mode  = 2'($urandom);
            cfg_speed = 3'($urandom);
            cfg_dir   = 1'($urandom);
            pal_we    = ($urandom_range(0, 3) == 0);
            pal_addr  = 2'($urandom);
            pal_wdata = 6'($urandom);
            rand_pixel();
            step();
        end
        rst_n = 1'b1; fs = 1'b0; pal_we = 1'b0;
        repeat (2) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/background_engine.md
# background_engine

Parametrised, registered successor of the combinational background pattern generator. It holds an internal palette, produces its own animation time base from frame pulses, and applies mode, speed and direction changes only at frame boundaries. It sits between the timing generator (pixel counters, frame pulse) and the sprite/priority mixer, and delivers one background colour per pixel with fixed one-cycle latency.

## Interface
- `HTOTAL`, 800: total horizontal pixels; `counter_h` width is `$clog2(HTOTAL)+1`, signed.
- `VTOTAL`, 525: total vertical pixels; `counter_v` width is `$clog2(VTOTAL)+1`, signed.
- `COLOR_W`, 6: colour width (RRGGBB).
- `NUM_COLORS`, 4: palette depth; power of two, at least 2. `PAL_AW = $clog2(NUM_COLORS)`.
- `TIME_W`, 8: animation time width.
- `STRIPE_SHIFT`, 5: log2 of the stripe/band width in pixels.
- `clk`  in  1: pixel clock.
- `reset_n`  in  1: synchronous, active-low reset.
- `frame_start`  in  1: one-cycle pulse, once per frame, during vertical blanking.
- `counter_h`  in  `$clog2(HTOTAL)+1`: current signed horizontal position.
- `counter_v`  in  `$clog2(VTOTAL)+1`: current signed vertical position.
- `cfg_mode`  in  2: requested pattern mode.
- `cfg_speed`  in  3: frames per time step; 0 freezes the time base.
- `cfg_dir`  in  1: 0 counts time up, 1 counts it down.
- `pal_we`  in  1: palette write strobe.
- `pal_addr`  in  `PAL_AW`: palette write index.
- `pal_wdata`  in  `COLOR_W`: palette write data.
- `color_out`  out  `COLOR_W`: registered background colour.
- `cur_time`  out  `TIME_W`: current animation time, registered.

## Operation
- Reset (`reset_n`=0 at a clock edge) clears the following to 0:
  - `color_out` and `cur_time`;
  - every palette entry;
  - the frame divider;
  - the shadow mode, speed and direction registers.
- Shadow config:
  - On a `frame_start` cycle, the shadow registers capture `cfg_mode`, `cfg_speed` and `cfg_dir`.
  - Config changes outside `frame_start` are ignored until the next pulse.
- Time base, evaluated on a `frame_start` cycle using the newly captured speed `S`:
  - `S`=0: the divider clears and time holds.
  - Otherwise the divider increments. When it reaches `S-1` it clears, and time steps by +1 (dir 0) or -1 (dir 1), modulo 2^TIME_W.
  - Wrap is silent: 255+1 gives 0, and 0-1 gives 255.
  - A speed change takes effect from that same pulse because the divider compares against the new `S`.
- Pattern index arithmetic:
  - The counters are sign-extended and `cur_time` is zero-extended to a common width `W = max(h,v width)+2`.
  - All sums are two's complement modulo 2^W, and index bits come from that result.
- Modes, using the shadow mode:
  - 0, solid: output `palette[0]`.
  - 1, xor: output `((h[7:2] ^ v[7:2]) + time[7:2])`, zero-extended or truncated to `COLOR_W`. The palette is bypassed.
  - 2, diagonal: output `palette[((h+v+time) >> STRIPE_SHIFT) mod NUM_COLORS]`.
  - 3, bands: output `palette[((v+time) >> STRIPE_SHIFT) mod NUM_COLORS]`.
- Palette writes:
  - The write commits at the clock edge.
  - A pixel whose lookup is sampled in the same cycle as the write sees the old entry. The next cycle sees the new entry.

## Timing
- `color_out` at edge t+1 reflects `counter_h`/`counter_v` sampled at edge t, together with the shadow config and `cur_time` valid during cycle t. Latency is exactly 1 cycle.
- `cur_time` and the shadow registers update at the edge that ends the `frame_start` cycle. Pixels sampled from the next cycle onward use the new values.
- Reset mid-frame:
  - `color_out` is 0 on the following cycle.
  - The palette must be reloaded.
  - The time base restarts at 0 and stays frozen (speed 0) until a `frame_start` with nonzero `cfg_speed` arrives.
- `frame_start` asserted on consecutive cycles counts as one frame per asserted cycle. Keeping it a single pulse is the timing generator's responsibility.
- When reset and `frame_start` or `pal_we` are asserted in the same cycle, reset wins.

## Structure
- Package `background_pkg` holds:
  - `typedef enum logic [1:0] bg_mode_e {BG_SOLID, BG_XOR, BG_DIAG, BG_BANDS}`;
  - the default `COLOR_W` localparam.
- Sub-module `bg_time_gen` contains the shadow speed/dir registers, the frame divider and the up/down time counter, with parameter `TIME_W`.
- Palette index selection and the output register stay in the top module.

## Test plan
- **Reset:** hold `reset_n`=0 for 2 cycles with random inputs → `color_out`=0, `cur_time`=0; mode 0 with all palette entries 0 gives output 0.
- **Shadow config:**
  - Write `palette[0]`=6'h2A, drive `cfg_mode`=0, pulse `frame_start` → `color_out`=6'h2A, 1 cycle after any counter change.
  - Switch `cfg_mode` to 3 without a pulse → output unchanged.
- **Time base:**
  - `cfg_speed`=3, dir 0: after 9 `frame_start` pulses `cur_time`=3.
  - `cfg_speed`=0: 5 pulses leave `cur_time` unchanged.
- **Wrap:**
  - From `cur_time`=0, dir 1, speed 1: one pulse → `cur_time`=255.
  - Continue with dir 0: one pulse → 0.
- **Diagonal mode:** palette = {01,02,03,04}, mode 2, time 0, `STRIPE_SHIFT`=5. Expected outputs:
  - h=0, v=0 → 6'h01;
  - h=32, v=0 → 6'h02;
  - h=-1, v=0 → 6'h04.
- **Write/read collision:** mode 0, write `palette[0]`=6'h11 in the same cycle as a pixel sample → that pixel shows the old value, the next pixel shows 6'h11.
